// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, FSM state and buffer entry type for instruction_fetch
package ifetch_pkg;
   localparam int INSTR_W = 24;
   localparam int WORD_W = 48;
   localparam int PC_W = 12;
   localparam int ADR_W = PC_W - 1;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 12'h800;
   typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: memory read, redirect and decode handshake signals of instruction_fetch
interface ifetch_if;
   import ifetch_pkg::*;
   logic [WORD_W-1:0] memdata;
   logic mem_valid, memread, redirect, instr_valid, instr_ready;
   logic [ADR_W-1:0] adr;
   logic [PC_W-1:0] redirect_pc, instr_pc;
   logic [INSTR_W-1:0] instr;
   modport master (
      input  memdata, mem_valid, redirect, redirect_pc, instr_ready,
      output memread, adr, instr, instr_pc, instr_valid
   );
   modport slave (
      output memdata, mem_valid, redirect, redirect_pc, instr_ready,
      input  memread, adr, instr, instr_pc, instr_valid
   );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: {pc, instr} buffer with dual enqueue port, flush and occupancy count
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic enq0,
   input  logic enq1,
   input  logic deq,
   input  entry_t din0,
   input  entry_t din1,
   output entry_t dout,
   output logic valid,
   output logic [AW:0] count
);
   entry_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic [1:0] n_in;
   logic pop;
   assign valid = count != '0;
   assign dout = valid ? mem[rd] : '0;
   always_comb begin
      n_in = enq1 ? 2'd2 : {1'b0, enq0};
      pop = deq & valid;
   end
   always_ff @(posedge clk) begin
      if (enq0) mem[wr] <= din0;
      if (enq1) mem[wr + AW'(1)] <= din1;
   end
   // flush wins over a same-cycle push/pop; the popped head was still presented this cycle
   always_ff @(posedge clk or posedge reset)
      if (reset || flush) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         wr <= wr + AW'(n_in);
         rd <= rd + AW'(pop);
         count <= count + (AW+1)'(n_in) - (AW+1)'(pop);
      end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer and read FSM filling a {pc, instr} buffer toward decode.
// IFETCH_PAIR_FILL_EN: enqueue both halves of a memory word when fetching from an even pc.
module instruction_fetch
   import ifetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic reset,
   ifetch_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IFETCH_PAIR_FILL_EN
   localparam int NEED = 2;
`else
   localparam int NEED = 1;
`endif
   state_t state;
   logic [PC_W-1:0] pc;
   logic memread_q, can_req, take, pair;
   logic [CW-1:0] count;
   entry_t din0, din1, head;
   always_comb begin
      can_req = int'(count) <= FIFO_DEPTH - NEED;
      take = state == WAIT && bus.mem_valid && !bus.redirect;
`ifdef IFETCH_PAIR_FILL_EN
      pair = !pc[0];
`else
      pair = 1'b0;
`endif
      din0 = '{pc: pc, instr: pc[0] ? bus.memdata[INSTR_W-1:0] : bus.memdata[WORD_W-1:INSTR_W]};
      din1 = '{pc: pc + PC_W'(1), instr: bus.memdata[INSTR_W-1:0]};
   end
   ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .flush(bus.redirect),
      .enq0(take), .enq1(take & pair), .deq(bus.instr_ready),
      .din0(din0), .din1(din1), .dout(head), .valid(bus.instr_valid), .count(count)
   );
   assign bus.memread = memread_q;
   assign bus.adr = pc[PC_W-1:1];
   assign bus.instr = head.instr;
   assign bus.instr_pc = head.pc;
   // a response that is overtaken by a redirect is drained and dropped, never enqueued
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= REQ;
         pc <= RESET_PC;
         memread_q <= 1'b0;
      end else begin
         memread_q <= 1'b0;
         if (bus.redirect) pc <= bus.redirect_pc;
         else if (take) pc <= pc + (pair ? PC_W'(2) : PC_W'(1));
         case (state)
            REQ: if (!bus.redirect && can_req) begin
               memread_q <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (bus.mem_valid) state <= REQ;
               else if (bus.redirect) state <= DRAIN;
            DRAIN: if (bus.mem_valid) state <= REQ;
            default: state <= REQ;
         endcase
      end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors plus hand-written redirect/backpressure sequences.
module tb_instruction_fetch;
`ifdef IFETCH_PAIR_FILL_EN
   localparam bit PAIR = 1'b1;
`else
   localparam bit PAIR = 1'b0;
`endif
   typedef struct packed {
      logic [11:0] start_pc;
      int lat;
      logic [2:0][10:0] adr_p;
      logic [2:0][10:0] adr_s;
      logic [3:0][11:0] pcs;
   } vec_t;

   logic clk, reset;
   ifetch_if bus();
   instruction_fetch dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0, passed = 0;
   int lat = 1;
   bit fixed = 1'b1;
   bit pend = 1'b0;
   int cnt = 0;
   logic [10:0] padr = '0;
   logic [11:0] got_pc[$];
   logic [23:0] got_instr[$];
   logic [10:0] req_adr[$];
   vec_t tbl[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [23:0] gen_instr(logic [11:0] p);
      return p[0] ? {12'hD00, p} : {12'hE00, p};
   endfunction

   function automatic vec_t mk(logic [11:0] s, int l, logic [10:0] a0, a1, a2, b0, b1, b2,
                               logic [11:0] p0, p1, p2, p3);
      vec_t v;
      v.start_pc = s;
      v.lat = l;
      v.adr_p = {a2, a1, a0};
      v.adr_s = {b2, b1, b0};
      v.pcs = {p3, p2, p1, p0};
      return v;
   endfunction

   // memory: fixed latency after each memread, one cycle of mem_valid
   always @(posedge clk) begin
      #1;
      bus.mem_valid = 1'b0;
      if (pend) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            pend = 1'b0;
            bus.mem_valid = 1'b1;
            bus.memdata = fixed ? 48'hAAAAAA_BBBBBB : {12'hE00, padr, 1'b0, 12'hD00, padr, 1'b1};
         end
      end
      if (bus.memread) begin
         pend = 1'b1;
         cnt = lat;
         padr = bus.adr;
      end
   end

   always @(negedge clk) begin
      if (bus.memread) req_adr.push_back(bus.adr);
      if (bus.instr_valid && bus.instr_ready) begin
         got_pc.push_back(bus.instr_pc);
         got_instr.push_back(bus.instr);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic clear();
      got_pc.delete();
      got_instr.delete();
      req_adr.delete();
   endtask

   task automatic do_redirect(logic [11:0] p);
      bus.redirect = 1'b1;
      bus.redirect_pc = p;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
      clear();
   endtask

   task automatic run_until(int ng, int na, int budget);
      int c = 0;
      while ((got_pc.size() < ng || req_adr.size() < na) && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (got_pc.size() < ng || req_adr.size() < na) begin
         checks++;
         $display("FAIL timeout: %0d deliveries %0d reads, wanted %0d/%0d", got_pc.size(), req_adr.size(), ng, na);
      end
   endtask

   task automatic wait_memread();
      int c = 0;
      while (!bus.memread && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (!bus.memread) begin
         checks++;
         $display("FAIL memread_timeout: no read within %0d cycles", c);
      end
   endtask

   task automatic valid_edges(string name, int exp);
      int c = 0;
      while (!bus.instr_valid && c < 50) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk(name, c, exp);
   endtask

   initial begin
      tbl[0] = mk(12'h123, 3, 11'h091, 11'h092, 11'h093, 11'h091, 11'h092, 11'h092, 12'h123, 12'h124, 12'h125, 12'h126);
      tbl[1] = mk(12'hFFE, 1, 11'h7FF, 11'h000, 11'h001, 11'h7FF, 11'h7FF, 11'h000, 12'hFFE, 12'hFFF, 12'h000, 12'h001);
      tbl[2] = mk(12'h010, 2, 11'h008, 11'h009, 11'h00A, 11'h008, 11'h008, 11'h009, 12'h010, 12'h011, 12'h012, 12'h013);
      tbl[3] = mk(12'hFFF, 4, 11'h7FF, 11'h000, 11'h001, 11'h7FF, 11'h000, 11'h000, 12'hFFF, 12'h000, 12'h001, 12'h002);
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = 1'b1;
      bus.mem_valid = 1'b0;
      bus.memdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_memread", bus.memread, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_adr", bus.adr, 11'h400);
      chk("rst_instr", bus.instr, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear();
      valid_edges("first_valid_edges", 3);
      run_until(2, 3, 100);
      chk("boot_adr0", req_adr[0], 11'h400);
      chk("boot_adr1", req_adr[1], PAIR ? 11'h401 : 11'h400);
      chk("boot_adr2", req_adr[2], PAIR ? 11'h402 : 11'h401);
      chk("boot_pc0", got_pc[0], 12'h800);
      chk("boot_instr0", got_instr[0], 24'hAAAAAA);
      chk("boot_pc1", got_pc[1], 12'h801);
      chk("boot_instr1", got_instr[1], 24'hBBBBBB);
      fixed = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lat = tbl[i].lat;
         do_redirect(tbl[i].start_pc);
         run_until(4, 3, 200);
         for (int j = 0; j < 3; j++)
            chk($sformatf("vec%0d_adr%0d", i, j), req_adr[j], PAIR ? tbl[i].adr_p[j] : tbl[i].adr_s[j]);
         for (int j = 0; j < 4; j++) begin
            chk($sformatf("vec%0d_pc%0d", i, j), got_pc[j], tbl[i].pcs[j]);
            chk($sformatf("vec%0d_instr%0d", i, j), got_instr[j], gen_instr(tbl[i].pcs[j]));
         end
      end
      // backpressure: buffer fills, reads stop, order preserved on release
      lat = 1;
      bus.instr_ready = 1'b0;
      do_redirect(12'h200);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      chk("bp_reads", req_adr.size(), PAIR ? 2 : 4);
      chk("bp_valid", bus.instr_valid, 1);
      chk("bp_none_taken", got_pc.size(), 0);
      bus.instr_ready = 1'b1;
      run_until(6, 0, 100);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp_pc%0d", i), got_pc[i], 12'h200 + 12'(i));
         chk($sformatf("bp_instr%0d", i), got_instr[i], gen_instr(12'h200 + 12'(i)));
      end
      // refill, then redirect with a dequeue on the same cycle: buffer empty afterwards
      lat = 2;
      bus.instr_ready = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      chk("pre_flush_valid", bus.instr_valid, 1);
      bus.instr_ready = 1'b1;
      do_redirect(12'h300);
      chk("flush_valid", bus.instr_valid, 0);
      // redirect coincident with mem_valid
      wait_memread();
      repeat (2) @(posedge clk);
      #1;
      do_redirect(12'h456);
      valid_edges("coinc_valid_edges", 4);
      run_until(1, 2, 100);
      chk("coinc_adr0", req_adr[0], 11'h22B);
      chk("coinc_adr1", req_adr[1], PAIR ? 11'h22C : 11'h22B);
      chk("coinc_pc0", got_pc[0], 12'h456);
      chk("coinc_instr0", got_instr[0], gen_instr(12'h456));
      // redirect while waiting on a slow read: stale response dropped
      lat = 3;
      do_redirect(12'h700);
      wait_memread();
      @(posedge clk);
      #1;
      do_redirect(12'h123);
      run_until(3, 2, 100);
      chk("drain_adr0", req_adr[0], 11'h091);
      chk("drain_adr1", req_adr[1], 11'h092);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain_pc%0d", i), got_pc[i], 12'h123 + 12'(i));
         chk($sformatf("drain_instr%0d", i), got_instr[i], gen_instr(12'h123 + 12'(i)));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'h800, instruction address loaded into PC on reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction-buffer entries (power of two, >=2).
REQ-003 Ports: clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 memdata  in  48  memory read word; bits [0:23] even instruction, [24:47] odd instruction.
REQ-006 mem_valid  in  1  memdata valid for the outstanding read.
REQ-007 memread  out  1  one-cycle read request pulse.
REQ-008 adr  out  11  word address (PC bits [0:10]), valid while memread=1.
REQ-009 redirect  in  1  branch/jump taken; flush and restart fetch.
REQ-010 redirect_pc  in  12  new instruction address, sampled when redirect=1.
REQ-011 instr  out  24  instruction at buffer head, toward instruction_fields decode.
REQ-012 instr_pc  out  12  address of instr.
REQ-013 instr_valid  out  1  buffer non-empty.
REQ-014 instr_ready  in  1  decode accepts; transfer when instr_valid and instr_ready both 1.

Function
REQ-015 PC is 12 bits and counts instructions; adr = pc[0:10]; pc[11] selects the half-word.
REQ-016 FSM states: REQ, WAIT, DRAIN.
REQ-017 REQ: when buffer free slots >= 2 and no redirect, memread=1 for one cycle, next WAIT; otherwise memread=0, stay REQ.
REQ-018 WAIT: on mem_valid, enqueue {pc, memdata half selected by pc[11]}, advance pc, next REQ.
REQ-019 Pair fill (see REQ-030): in WAIT with pc[11]=0, also enqueue {pc+1, memdata[24:47]}; pc advances by 2; with pc[11]=1, one entry, pc advances by 1.
REQ-020 PC arithmetic is modulo 4096; 12'hFFF+1 = 12'h000; pair at 12'hFFE enqueues FFE, FFF, then pc=000.
REQ-021 Memory latency >= 1 cycle after memread; at most one read outstanding.
REQ-022 Redirect in any state: buffer flushed the same edge, pc <= redirect_pc, instr_valid=0 next cycle.
REQ-023 Redirect in WAIT without mem_valid: next DRAIN; the next mem_valid is discarded, then next REQ.
REQ-024 Redirect in WAIT with mem_valid on the same cycle: response discarded, next REQ.
REQ-025 Redirect in DRAIN: pc updated, remain DRAIN until the outstanding response arrives.
REQ-026 Redirect has priority over enqueue and dequeue on the same cycle; a dequeue on that cycle is still delivered to decode, then the buffer is emptied.
REQ-027 Enqueue and dequeue on the same cycle are both honoured; count unchanged for 1-in/1-out.
REQ-028 Buffer never overflows: REQ-017 free-slot check guarantees space for 2 entries.

Reset
REQ-029 On reset: state REQ, pc=RESET_PC, buffer empty, instr_valid=0, memread=0, adr=RESET_PC[0:10], instr=0, instr_pc=0; first memread no earlier than the first clock edge after deassertion.

Configuration
REQ-030 Macro IFETCH_PAIR_FILL_EN: defined -> REQ-019 pair fill active; undefined -> exactly one instruction enqueued per read, pc advances by 1, and REQ-017 requires >= 1 free slot.

Structure
REQ-031 Package ifetch_pkg holds the FSM state enum, RESET_PC default, width constants (INSTR_W=24, WORD_W=48, PC_W=12).
REQ-032 One sub-module ifetch_fifo: synchronous FIFO, dual enqueue port, flush input, holding {pc, instr}.

Verification
REQ-033 Reset, mem latency 1, memdata=48'hAAAAAA_BBBBBB, instr_ready=1 -> memread with adr=11'h400; instr AAAAAA@800 then BBBBBB@801; next adr=11'h401.
REQ-034 instr_ready=0 for 10 cycles -> buffer fills to 4, memread stops, no entry lost or reordered once ready=1.
REQ-035 redirect=1, redirect_pc=12'h123 while in WAIT, latency 3 -> stale response dropped; next adr=11'h091; first instr_pc=123 (single entry), then 124/125 pair.
REQ-036 redirect coincident with mem_valid -> response never appears on instr; next memread adr from redirect_pc.
REQ-037 redirect_pc=12'hFFE -> instr_pc sequence FFE, FFF, 000; adr wraps 7FF -> 000.
REQ-038 Build without IFETCH_PAIR_FILL_EN, same stimulus as REQ-033 -> one instr per read, adr sequence 400, 400, 401.
